rgb_fifo_packer: RTL and testbench
==================================

// Module: rgb_fifo_packer
// PURPOSE
//  Upstream stage of the output-FIFO path: takes an 8-bit serial channel stream (R,G,B per pixel),
//  packs each triplet into one 24-bit word {R,G,B} and writes it to the output FIFO.
//  Tracks frame geometry from in_sof and width x height, flags sync errors and marks frame end.
//  The downstream consumer pops words and unpacks [23:16]/[15:8]/[7:0].
// PARAMETERS
//  DWIDTH     8   bits per colour channel
//  CHANNELS   3   channel beats per pixel; first beat lands in the MSB slot
// PORTS
//  clock        in   1                 system clock, rising edge
//  reset_n      in   1                 asynchronous active-low reset
//  width        in   11                pixels per line, sampled on the accepted in_sof beat
//  height       in   11                lines per frame, sampled on the accepted in_sof beat
//  in_valid     in   1                 channel beat valid
//  in_ready     out  1                 beat accepted when in_valid & in_ready
//  in_data      in   DWIDTH            channel sample
//  in_sof       in   1                 marks channel 0 of pixel 0 of a frame
//  fifo_wrreq   out  1                 FIFO write strobe
//  fifo_data    out  CHANNELS*DWIDTH   packed pixel, valid while fifo_wrreq=1
//  fifo_full    in   1                 FIFO full
//  frame_done   out  1                 1-cycle pulse: last pixel of frame written to FIFO
//  sync_err     out  1                 1-cycle pulse: in_sof misalignment detected
//  frame_cnt    out  16                [PACK_STATS_EN] completed frames, wraps 0xFFFF->0
//  drop_cnt     out  16                [PACK_STATS_EN] beats discarded in IDLE, saturates 0xFFFF
// BEHAVIOUR
//  Reset: state=IDLE, ch_idx=0, pix_cnt=0, word_valid=0; in_ready=1, fifo_wrreq=0, fifo_data=0,
//   frame_done=0, sync_err=0, frame_cnt=0, drop_cnt=0. Reset mid-frame discards partial word/pixel.
//  FSM IDLE: in_ready=1; accepted beat without in_sof is dropped (drop_cnt++). Accepted beat with
//   in_sof: latch width/height; if either is 0, drop and pulse sync_err, stay IDLE; else
//   store as channel 0, go ACTIVE.
//  FSM ACTIVE: ch_idx counts 0..CHANNELS-1 per accepted beat; beat k goes to
//   fifo_data[(CHANNELS-k)*DWIDTH-1 -: DWIDTH]. On channel CHANNELS-1 the word is loaded into
//   holding register (word_valid=1), pix_cnt++ (width*height computed as 22-bit).
//  Output: fifo_wrreq = word_valid & ~fifo_full (combinational from registers); word_valid clears
//   when written. Latency last beat accepted -> fifo_wrreq = 1 cycle when FIFO not full.
//  Backpressure: in_ready = ~word_valid | ~fifo_full (in ACTIVE); simultaneous drain and reload of
//   holding register in one cycle is legal, giving one pixel per CHANNELS cycles sustained.
//  fifo_full held: word stays, in_ready=0, no data lost; new word never overwrites an unwritten one.
//  Frame end: when pix_cnt reaches width*height the final word is written, frame_done pulses in the
//   cycle its fifo_wrreq is asserted, pix_cnt=0, state -> IDLE.
//  in_sof in ACTIVE with ch_idx!=0 or pix_cnt!=0: pulse sync_err, discard partial pixel, restart
//   frame with this beat as channel 0 (re-latch width/height). Pending full word is still written.
//  in_sof exactly on expected frame boundary (frame completes, IDLE) behaves as a normal start.
// CONFIGURATION
//  PACK_STATS_EN defined: frame_cnt and drop_cnt ports and counters present as above.
//  Not defined: both ports and counters are removed; all other behaviour identical.
// TESTING
//  W=4,H=2, 24 beats 0x01..0x18, sof on first, fifo_full=0 -> 8 writes 0x010203..0x161718, frame_done once, frame_cnt=1.
//  Same frame, fifo_full=1 for 10 cycles after word 3 -> in_ready=0, word 0x070809 held, no loss/duplication.
//  5 beats with in_sof=0 before sof -> dropped, no wrreq, drop_cnt=5, then frame packs normally.
//  in_sof on beat 2 of pixel 1 -> sync_err 1 pulse, word 0x010203 written, new frame restarts from that beat.
//  width=0 with in_sof -> sync_err, state stays IDLE, fifo_wrreq never asserted.
//  reset_n low mid-pixel (ch_idx=1) -> all outputs to reset values, next sof frame packs cleanly.

Source files
------------

// File: rtl/rgb_fifo_packer.sv
// Packs a serial R,G,B channel stream into {R,G,B} words for the output FIFO, tracking frame geometry.
// Optional PACK_STATS_EN adds frame_cnt / drop_cnt statistics ports.
module rgb_fifo_packer #(
    parameter int DWIDTH   = 8,
    parameter int CHANNELS = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [10:0]                  width,
    input  logic [10:0]                  height,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DWIDTH-1:0]            in_data,
    input  logic                         in_sof,
    output logic                         fifo_wrreq,
    output logic [CHANNELS*DWIDTH-1:0]   fifo_data,
    input  logic                         fifo_full,
    output logic                         frame_done,
    output logic                         sync_err
`ifdef PACK_STATS_EN
    ,
    output logic [15:0]                  frame_cnt,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int WORD_W = CHANNELS * DWIDTH;
    localparam int ACC_W  = (CHANNELS - 1) * DWIDTH;
    localparam int CI_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CI_W-1:0] LAST_CH = CI_W'(CHANNELS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q;
    logic [CI_W-1:0]   ch_idx_q;
    logic [21:0]       pix_cnt_q;
    logic [21:0]       total_q;
    logic [ACC_W-1:0]  acc_q;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic              word_last_q;
    logic              sync_err_q;

    logic        wr_fire;
    logic        accept;
    logic        geom_ok;
    logic        last_pix;
    logic [21:0] total_d;

    assign wr_fire    = word_valid_q & ~fifo_full;
    assign fifo_wrreq = wr_fire;
    assign fifo_data  = word_q;
    assign frame_done = wr_fire & word_last_q;
    assign sync_err   = sync_err_q;

    // IDLE beats never complete a word, so they are always accepted even while a word is held.
    assign in_ready = (state_q == IDLE) | ~word_valid_q | ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign geom_ok  = (width != 11'd0) && (height != 11'd0);
    assign total_d  = {11'd0, width} * {11'd0, height};
    assign last_pix = (pix_cnt_q + 22'd1) == total_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ch_idx_q     <= '0;
            pix_cnt_q    <= '0;
            total_q      <= '0;
            acc_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            if (wr_fire) begin
                word_valid_q <= 1'b0;
                word_last_q  <= 1'b0;
            end
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (in_sof) begin
                            if (geom_ok) begin
                                total_q   <= total_d;
                                acc_q     <= ACC_W'(in_data);
                                ch_idx_q  <= CI_W'(1);
                                pix_cnt_q <= '0;
                                state_q   <= ACTIVE;
                            end else begin
                                sync_err_q <= 1'b1;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (in_sof) begin
                            // Misaligned start: drop the partial pixel but keep any held word.
                            sync_err_q <= (ch_idx_q != '0) || (pix_cnt_q != '0);
                            pix_cnt_q  <= '0;
                            if (geom_ok) begin
                                total_q  <= total_d;
                                acc_q    <= ACC_W'(in_data);
                                ch_idx_q <= CI_W'(1);
                            end else begin
                                ch_idx_q <= '0;
                                state_q  <= IDLE;
                            end
                        end else if (ch_idx_q == LAST_CH) begin
                            word_q       <= {acc_q, in_data};
                            word_valid_q <= 1'b1;
                            word_last_q  <= last_pix;
                            ch_idx_q     <= '0;
                            if (last_pix) begin
                                pix_cnt_q <= '0;
                                state_q   <= IDLE;
                            end else begin
                                pix_cnt_q <= pix_cnt_q + 22'd1;
                            end
                        end else begin
                            acc_q    <= ACC_W'({acc_q, in_data});
                            ch_idx_q <= ch_idx_q + CI_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef PACK_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        drop_beat;

    assign drop_beat = accept & (state_q == IDLE) & (~in_sof | ~geom_ok);
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (frame_done)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drop_beat && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rgb_fifo_packer.sv
// Randomized bench for rgb_fifo_packer against a pixel-level queue model of the packing rules.
module tb_rgb_fifo_packer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] width, height;
    logic        in_valid, in_ready, in_sof;
    logic [7:0]  in_data;
    logic        fifo_wrreq, fifo_full, frame_done, sync_err;
    logic [23:0] fifo_data;
`ifdef PACK_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
`endif

    rgb_fifo_packer dut (
        .clock(clock), .reset_n(reset_n), .width(width), .height(height),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_full(fifo_full),
        .frame_done(frame_done), .sync_err(sync_err)
`ifdef PACK_STATS_EN
        , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_err = 0;
    bit rnd_full = 0;

    typedef struct { logic [23:0] w; bit last; } exp_t;
    exp_t       mq[$];
    logic [7:0] m_part[$];
    bit         m_active = 0;
    int         m_pix = 0, m_total = 0;
    int         exp_sync = 0, obs_sync = 0;
    int         exp_frames = 0, obs_done = 0;
    int         exp_drops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel-level model: collect accepted beats into a list, emit a word every three.
    task automatic model_beat(input logic [7:0] d, input logic sof);
        bit ok;
        ok = (width != 0) && (height != 0);
        if (!m_active) begin
            if (sof && ok) begin
                m_active = 1; m_total = int'(width) * int'(height); m_pix = 0;
                m_part.delete(); m_part.push_back(d);
            end else begin
                if (sof) exp_sync++;
                if (exp_drops < 65535) exp_drops++;
            end
        end else if (sof) begin
            exp_sync++;
            m_part.delete(); m_pix = 0;
            if (ok) begin m_total = int'(width) * int'(height); m_part.push_back(d); end
            else m_active = 0;
        end else begin
            m_part.push_back(d);
            if (m_part.size() == 3) begin
                exp_t e;
                e.w = {m_part[0], m_part[1], m_part[2]};
                e.last = (m_pix + 1 == m_total);
                mq.push_back(e);
                m_pix++;
                m_part.delete();
                if (m_pix == m_total) begin m_active = 0; m_pix = 0; end
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            mq.delete(); m_part.delete(); m_active = 0; m_pix = 0;
            exp_frames = 0; obs_done = 0; exp_drops = 0;
        end else begin
            if (fifo_wrreq) begin
                if (mq.size() == 0) check("unexp_wr", fifo_wrreq, 0);
                else begin
                    exp_t e;
                    e = mq.pop_front();
                    check("wr_data", fifo_data, e.w);
                    check("wr_done", frame_done, e.last);
                    if (e.last) exp_frames++;
                end
            end else if (frame_done) check("stray_done", frame_done, 0);
            if (frame_done) obs_done++;
            if (sync_err) obs_sync++;
            if (in_valid && in_ready) model_beat(in_data, in_sof);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        bit ok = 0;
        in_valid = 1; in_data = d; in_sof = sof;
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
            @(posedge clock); #1;
            if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
        end
        check("send_timeout", ok, 1);
        @(posedge clock); #1;
        in_valid = 0; in_sof = 0;
        if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        reset_n = 0; in_valid = 0; in_sof = 0; fifo_full = 0;
        @(negedge clock);
        check("rst_ready", in_ready, 1);
        check("rst_wrreq", fifo_wrreq, 0);
        check("rst_data", fifo_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_sync", sync_err, 0);
`ifdef PACK_STATS_EN
        check("rst_fcnt", frame_cnt, 0);
        check("rst_dcnt", drop_cnt, 0);
`endif
        @(posedge clock); #1;
        reset_n = 1;
    endtask

    task automatic frame_rand(input int w, input int h);
        width = 11'(w); height = 11'(h);
        for (int i = 0; i < w * h * 3; i++) begin
            send(8'($urandom_range(0, 255)), i == 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        width = 4; height = 2; in_valid = 0; in_data = 0; in_sof = 0; fifo_full = 0; reset_n = 0;
        do_reset();

        // Clean 4x2 frame, with first-word latency check
        send(8'h01, 1); send(8'h02, 0); send(8'h03, 0);
        @(negedge clock);
        check("lat_wrreq", fifo_wrreq, 1);
        check("lat_data", fifo_data, 24'h010203);
        @(posedge clock); #1;
        for (int i = 4; i <= 24; i++) send(8'(i), 0);
        idle(4);
        check("t1_done", obs_done, 1);
        check("t1_drain", mq.size(), 0);
`ifdef PACK_STATS_EN
        check("t1_fcnt", frame_cnt, 1);
`endif

        // Backpressure holds word 0x070809
        for (int i = 1; i <= 6; i++) send(8'(i), i == 1);
        idle(1);
        fifo_full = 1;
        for (int i = 7; i <= 9; i++) send(8'(i), 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("hold_ready", in_ready, 0);
            check("hold_wrreq", fifo_wrreq, 0);
            check("hold_data", fifo_data, 24'h070809);
            @(posedge clock); #1;
        end
        fifo_full = 0;
        for (int i = 10; i <= 24; i++) send(8'(i), 0);
        idle(4);
        check("t2_done", obs_done, 2);
        check("t2_drain", mq.size(), 0);

        // Beats before sof are dropped
        do_reset();
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)), 0);
        idle(3);
`ifdef PACK_STATS_EN
        check("t3_drop", drop_cnt, 5);
`endif
        frame_rand(4, 2);
        idle(4);
        check("t3_done", obs_done, 1);

        // Misaligned sof on second beat of pixel 1
        width = 4; height = 2;
        for (int i = 1; i <= 4; i++) send(8'(i), i == 1);
        send(8'h05, 1);
        @(negedge clock);
        check("t4_sync", sync_err, 1);
        @(posedge clock); #1;
        for (int i = 6; i <= 28; i++) send(8'(i), 0);
        idle(4);
        check("t4_drain", mq.size(), 0);
        check("t4_done", obs_done, 2);

        // Zero geometry
        width = 0; height = 2;
        send(8'hAA, 1);
        @(negedge clock);
        check("t5_sync", sync_err, 1);
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("t5_nowr", fifo_wrreq, 0);
            @(posedge clock); #1;
        end

        // Reset in the middle of a pixel
        width = 4; height = 2;
        send(8'h01, 1);
        do_reset();
        frame_rand(4, 2);
        idle(4);
        check("t6_done", obs_done, 1);

        // Randomized frames, backpressure, stray beats, restarts
        rnd_full = 1;
        for (int f = 0; f < 14; f++) begin
            int w, h, r, n, cut;
            w = $urandom_range(1, 5); h = $urandom_range(1, 3); r = $urandom_range(0, 7);
            n = w * h * 3;
            if (r == 0) begin
                width = 0; height = 11'(h);
                send(8'($urandom_range(0, 255)), 1);
            end
            if (r == 2) begin
                send(8'($urandom_range(0, 255)), 0);
                send(8'($urandom_range(0, 255)), 0);
            end
            if (r == 1) begin
                width = 11'(w); height = 11'(h);
                cut = $urandom_range(1, n - 1);
                for (int i = 0; i < cut; i++) send(8'($urandom_range(0, 255)), i == 0);
            end
            frame_rand(w, h);
            idle($urandom_range(0, 3));
        end
        rnd_full = 0; fifo_full = 0;
        idle(10);

        check("end_drain", mq.size(), 0);
        check("end_sync", obs_sync, exp_sync);
        check("end_done", obs_done, exp_frames);
`ifdef PACK_STATS_EN
        check("end_fcnt", frame_cnt, 16'(exp_frames));
        check("end_dcnt", drop_cnt, 16'(exp_drops));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
